crd_multilane: RTL

CRD_MULTILANE -- requirements
Module: crd_multilane

---
 rtl/crd_multilane.sv | 138 +++++++++++++
 1 files changed

// File: rtl/crd_multilane.sv
// rtl/crd_multilane.sv - multi-lane running-disparity checker, two-stage pipeline
// Optional per-lane saturating error counters when CRD_ERR_CNT_EN is defined.
module crd_multilane #(
    parameter int LANES = 4,
    parameter int SYM_W = 10,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [LANES*SYM_W-1:0] data_in,
    input  logic [LANES-1:0]       resync,
    input  logic                   clr_err,
    output logic                   out_valid,
    output logic [LANES-1:0]       rd_out,
    output logic [LANES-1:0]       rd_known,
    output logic [LANES-1:0]       disp_err,
    output logic [LANES-1:0]       code_err,
    output logic [LANES-1:0]       err_sticky,
    output logic [LANES*CNT_W-1:0] err_cnt
);
    localparam int HALF = SYM_W / 2;
    localparam int CW   = $clog2(SYM_W + 1);

    typedef enum logic [1:0] {RD_INIT = 2'd0, RD_NEG = 2'd1, RD_POS = 2'd2} rd_state_e;

    logic                   s1_valid_q;
    logic [LANES*SYM_W-1:0] s1_data_q;
    logic [LANES-1:0]       s1_resync_q;

    rd_state_e        state_q [LANES];
    rd_state_e        state_d [LANES];
    rd_state_e        cur_state [LANES];
    logic [CW-1:0]    lane_ones [LANES];

    logic             out_valid_q, out_valid_d;
    logic [LANES-1:0] rd_out_q, rd_out_d;
    logic [LANES-1:0] rd_known_q, rd_known_d;
    logic [LANES-1:0] disp_err_q, disp_err_d;
    logic [LANES-1:0] code_err_q, code_err_d;
    logic [LANES-1:0] err_sticky_q, err_sticky_d;

    function automatic logic [CW-1:0] ones(input logic [SYM_W-1:0] s);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < SYM_W; i++) c = c + CW'(s[i]);
        return c;
    endfunction

    always_comb begin
        out_valid_d  = s1_valid_q;
        rd_out_d     = '0;
        rd_known_d   = '0;
        disp_err_d   = '0;
        code_err_d   = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_ones[k] = ones(s1_data_q[k*SYM_W +: SYM_W]);
            // resync evaluates the symbol as if the lane had never locked
            cur_state[k] = s1_resync_q[k] ? RD_INIT : state_q[k];
            state_d[k]   = state_q[k];
            if (s1_valid_q) begin
                state_d[k] = cur_state[k];
                if (lane_ones[k] == CW'(HALF)) begin
                    state_d[k] = cur_state[k];
                end else if (lane_ones[k] == CW'(HALF + 1)) begin
                    if (cur_state[k] == RD_POS) disp_err_d[k] = 1'b1;
                    state_d[k] = RD_POS;
                end else if (lane_ones[k] == CW'(HALF - 1)) begin
                    if (cur_state[k] == RD_NEG) disp_err_d[k] = 1'b1;
                    state_d[k] = RD_NEG;
                end else begin
                    code_err_d[k] = 1'b1;
                end
                rd_out_d[k]   = (state_d[k] == RD_POS);
                rd_known_d[k] = (state_d[k] != RD_INIT);
            end
        end
        err_sticky_d = (clr_err ? '0 : err_sticky_q) | disp_err_d | code_err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_resync_q  <= '0;
            out_valid_q  <= 1'b0;
            rd_out_q     <= '0;
            rd_known_q   <= '0;
            disp_err_q   <= '0;
            code_err_q   <= '0;
            err_sticky_q <= '0;
            for (int k = 0; k < LANES; k++) state_q[k] <= RD_INIT;
        end else begin
            s1_valid_q   <= in_valid;
            s1_data_q    <= data_in;
            s1_resync_q  <= in_valid ? resync : '0;
            out_valid_q  <= out_valid_d;
            rd_out_q     <= rd_out_d;
            rd_known_q   <= rd_known_d;
            disp_err_q   <= disp_err_d;
            code_err_q   <= code_err_d;
            err_sticky_q <= err_sticky_d;
            for (int k = 0; k < LANES; k++) state_q[k] <= state_d[k];
        end
    end

`ifdef CRD_ERR_CNT_EN
    logic [LANES*CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [LANES-1:0]       lane_err;

    always_comb begin
        lane_err  = disp_err_d | code_err_d;
        err_cnt_d = err_cnt_q;
        for (int k = 0; k < LANES; k++) begin
            if (clr_err)
                err_cnt_d[k*CNT_W +: CNT_W] = lane_err[k] ? CNT_W'(1) : '0;
            else if (lane_err[k] && (err_cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                err_cnt_d[k*CNT_W +: CNT_W] = err_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign out_valid  = out_valid_q;
    assign rd_out     = rd_out_q;
    assign rd_known   = rd_known_q;
    assign disp_err   = disp_err_q;
    assign code_err   = code_err_q;
    assign err_sticky = err_sticky_q;
endmodule
